ex_issue_ctrl: RTL and testbench

//  Issue/writeback scheduler between decode and EX. EX has two units sharing one writeback port:
//  - a 1-cycle ALU
//  - a MUL_LATENCY-cycle pipelined multiplier

---
 rtl/ex_issue_ctrl_pkg.sv | 28 ++
 rtl/ex_wb_slot_shreg.sv | 80 ++++++++
 rtl/ex_issue_ctrl.sv | 87 ++++++++
 tb/tb_ex_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types and constants for the EX issue/writeback scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_issue_ctrl_pkg;

    // Register index width used by the writeback slot entries.
    localparam int INSTR_REG_SIZE = 5;

    // Default multiplier issue-to-writeback latency in cycles.
    localparam int MUL_LATENCY = 5;

    // One writeback slot: destination that will be written back when the entry reaches slot 0.
    typedef struct packed {
        logic                      valid;
        logic [INSTR_REG_SIZE-1:0] rd;
        logic                      is_mul;
    } wb_slot_t;

    // Build an occupied slot entry.
    function automatic wb_slot_t make_slot(input logic [INSTR_REG_SIZE-1:0] rd, input logic is_mul);
        wb_slot_t s;
        s.valid  = 1'b1;
        s.rd     = rd;
        s.is_mul = is_mul;
        return s;
    endfunction

endpackage

// File: rtl/ex_wb_slot_shreg.sv
// Writeback slot shift register: slot[k] retires k cycles from now; also produces busy vectors and occupancy.
// Latency: a reservation is visible in slot state the cycle after it is made; slot[0] is the registered WB head.
// Backpressure: none; the caller only reserves a slot it has already checked to be free.
module ex_wb_slot_shreg
    import ex_issue_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = ex_issue_ctrl_pkg::MUL_LATENCY,
    parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        res_en,
    input  logic                        res_is_mul,
    input  logic [INSTR_REG_SIZE-1:0]   res_rd,
    output wb_slot_t                    head,
    output logic [MUL_LATENCY-1:0]      slot_valid,
    output logic [2**INSTR_REG_SIZE-1:0] busy_all,
    output logic [2**INSTR_REG_SIZE-1:0] busy_pend,
    output logic [CNT_W-1:0]            cnt
);

    wb_slot_t slot [MUL_LATENCY];

    // Advance every slot one step toward writeback, then drop a new reservation at its latency position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                slot[i] <= slot[i+1];
            end
            slot[MUL_LATENCY-1] <= '0;
            if (res_en) begin
                if (res_is_mul) begin
                    slot[MUL_LATENCY-1] <= make_slot(res_rd, 1'b1);
                end else begin
                    slot[0] <= make_slot(res_rd, 1'b0);
                end
            end
        end
    end

    // Occupancy tracks reservations in and retirements out, so it always equals the number of valid slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(res_en) - CNT_W'(slot[0].valid);
        end
    end

    // busy_all covers every slot; busy_pend skips slot 0, whose value is already on the writeback bus.
    always_comb begin
        busy_all  = '0;
        busy_pend = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            if (slot[i].valid) begin
                busy_all[slot[i].rd] = 1'b1;
                if (i != 0) begin
                    busy_pend[slot[i].rd] = 1'b1;
                end
            end
        end
        busy_all[0]  = 1'b0;
        busy_pend[0] = 1'b0;
    end

    // Flatten slot occupancy for structural-hazard checks.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            slot_valid[i] = slot[i].valid;
        end
    end

    assign head = slot[0];

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue/writeback scheduler for a 1-cycle ALU and a pipelined multiplier sharing one WB port (option: EX_ISSUE_FWD_EN).
// Latency: issue decision is combinational; WB outputs come straight from registered slot 0 (ALU 1 cycle, MUL MUL_LATENCY).
// Backpressure: issue_ready_o drops on RAW, WAW or writeback-slot collision; stall_o holds decode while it is low.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = ex_issue_ctrl_pkg::MUL_LATENCY,
    parameter int REG_ADDR_W  = INSTR_REG_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid_i,
    input  logic                             issue_is_mul_i,
    input  logic                             issue_reg_write_i,
    input  logic                             issue_rs1_used_i,
    input  logic [REG_ADDR_W-1:0]            issue_rs1_i,
    input  logic                             issue_rs2_used_i,
    input  logic [REG_ADDR_W-1:0]            issue_rs2_i,
    input  logic [REG_ADDR_W-1:0]            issue_rd_i,
    input  logic                             flush_i,
    output logic                             issue_ready_o,
    output logic                             stall_o,
    output logic                             issue_fire_o,
    output logic                             wb_valid_o,
    output logic [REG_ADDR_W-1:0]            wb_rd_o,
    output logic                             wb_sel_mul_o,
    output logic [$clog2(MUL_LATENCY+1)-1:0] inflight_cnt_o
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    wb_slot_t                     head;
    logic [MUL_LATENCY-1:0]       slot_valid;
    logic [2**INSTR_REG_SIZE-1:0] busy_all;
    logic [2**INSTR_REG_SIZE-1:0] busy_pend;
    logic [2**INSTR_REG_SIZE-1:0] raw_busy;
    logic                         reserving;
    logic                         raw_hz;
    logic                         waw_hz;
    logic                         struct_hz;
    logic                         res_en;

    // With forwarding, a source retiring this cycle is taken off the WB bus, so only later slots block it.
`ifdef EX_ISSUE_FWD_EN
    assign raw_busy = busy_pend;
`else
    assign raw_busy = busy_all;
`endif

    // Hazard detection; readiness deliberately ignores issue_valid_i and flush_i.
    always_comb begin
        reserving = issue_reg_write_i & (issue_rd_i != '0);
        raw_hz    = (issue_rs1_used_i & raw_busy[issue_rs1_i]) |
                    (issue_rs2_used_i & raw_busy[issue_rs2_i]);
        // A destination retiring in slot 0 is free for a new writer.
        waw_hz    = reserving & busy_pend[issue_rd_i];
        // An ALU op lands in slot 0 next cycle, so it collides with whatever is now in slot 1.
        // A MUL lands past the top of the shift register, which is always empty.
        struct_hz = reserving & ~issue_is_mul_i & slot_valid[1];
    end

    assign issue_ready_o = ~(raw_hz | waw_hz | struct_hz);
    assign stall_o       = issue_valid_i & ~issue_ready_o;
    assign issue_fire_o  = issue_valid_i & issue_ready_o & ~flush_i & ~reset;
    assign res_en        = issue_fire_o & reserving;

    ex_wb_slot_shreg #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_slots (
        .clk        (clk),
        .reset      (reset),
        .res_en     (res_en),
        .res_is_mul (issue_is_mul_i),
        .res_rd     (issue_rd_i),
        .head       (head),
        .slot_valid (slot_valid),
        .busy_all   (busy_all),
        .busy_pend  (busy_pend),
        .cnt        (inflight_cnt_o)
    );

    assign wb_valid_o   = head.valid;
    assign wb_rd_o      = head.rd;
    assign wb_sel_mul_o = head.is_mul;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: directed scenarios plus randomized traffic against a writeback-schedule model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ex_issue_ctrl;

    localparam int ML = 5;
    localparam int RW = 5;
    localparam int CW = $clog2(ML + 1);
`ifdef EX_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid_i, issue_is_mul_i, issue_reg_write_i;
    logic          issue_rs1_used_i, issue_rs2_used_i, flush_i;
    logic [RW-1:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic          issue_ready_o, stall_o, issue_fire_o, wb_valid_o, wb_sel_mul_o;
    logic [RW-1:0] wb_rd_o;
    logic [CW-1:0] inflight_cnt_o;

    always #5 clk = ~clk;

    ex_issue_ctrl #(.MUL_LATENCY(ML), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid_i(issue_valid_i), .issue_is_mul_i(issue_is_mul_i),
        .issue_reg_write_i(issue_reg_write_i),
        .issue_rs1_used_i(issue_rs1_used_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs2_used_i(issue_rs2_used_i), .issue_rs2_i(issue_rs2_i),
        .issue_rd_i(issue_rd_i), .flush_i(flush_i),
        .issue_ready_o(issue_ready_o), .stall_o(stall_o), .issue_fire_o(issue_fire_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_sel_mul_o(wb_sel_mul_o),
        .inflight_cnt_o(inflight_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: list of outstanding writebacks, each with the absolute cycle on which it appears on WB.
    typedef struct {int rd; bit mul; int wbc;} ent_t;
    ent_t q[$];
    int   now = 0;

    bit exp_ready, exp_stall, exp_fire, exp_wbv, exp_wbmul;
    int exp_wbrd, exp_cnt;
    bit obs_ready, obs_stall, obs_fire, obs_wbv, obs_wbmul;
    int obs_wbrd, obs_cnt;

    bit log_fire[16], log_stall[16], log_wbv[16], log_sel[16];
    int log_rd[16], log_cnt[16];

    task automatic drive(input bit v, input bit m, input bit rw, input bit u1, input int r1,
                         input bit u2, input int r2, input int rd, input bit fl);
        issue_valid_i     = v;
        issue_is_mul_i    = m;
        issue_reg_write_i = rw;
        issue_rs1_used_i  = u1;
        issue_rs1_i       = RW'(r1);
        issue_rs2_used_i  = u2;
        issue_rs2_i       = RW'(r2);
        issue_rd_i        = RW'(rd);
        flush_i           = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: evaluate the model and sample the DUT at the falling edge, then advance past the rising edge.
    task automatic tick();
        bit raw, waw, st, resv;
        int lat;
        @(negedge clk);
        if (reset) q.delete();
        lat  = issue_is_mul_i ? ML : 1;
        resv = issue_reg_write_i && (issue_rd_i != 0);
        raw = 0; waw = 0; st = 0;
        exp_wbv = 0; exp_wbrd = 0; exp_wbmul = 0; exp_cnt = 0;
        foreach (q[i]) begin
            if (q[i].wbc >= now) exp_cnt++;
            if (q[i].wbc == now) begin
                exp_wbv = 1; exp_wbrd = q[i].rd; exp_wbmul = q[i].mul;
            end
            if (issue_rs1_used_i && q[i].rd == int'(issue_rs1_i) &&
                (FWD ? q[i].wbc > now : q[i].wbc >= now)) raw = 1;
            if (issue_rs2_used_i && q[i].rd == int'(issue_rs2_i) &&
                (FWD ? q[i].wbc > now : q[i].wbc >= now)) raw = 1;
            if (resv && q[i].rd == int'(issue_rd_i) && q[i].wbc > now) waw = 1;
            if (resv && q[i].wbc == now + lat) st = 1;
        end
        exp_ready = !(raw || waw || st);
        exp_stall = issue_valid_i && !exp_ready;
        exp_fire  = issue_valid_i && exp_ready && !flush_i && !reset;
        obs_ready = issue_ready_o; obs_stall = stall_o; obs_fire = issue_fire_o;
        obs_wbv   = wb_valid_o; obs_wbrd = int'(wb_rd_o); obs_wbmul = wb_sel_mul_o;
        obs_cnt   = int'(inflight_cnt_o);
        if (exp_fire && resv) q.push_back('{int'(issue_rd_i), issue_is_mul_i, now + lat});
        @(posedge clk);
        #1;
        now++;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].wbc < now) q.delete(i);
    endtask

    task automatic rec(input int k);
        log_fire[k] = obs_fire; log_stall[k] = obs_stall; log_wbv[k] = obs_wbv;
        log_rd[k] = obs_wbrd; log_sel[k] = obs_wbmul; log_cnt[k] = obs_cnt;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        bit stale;
        idle();
        tick(); tick();
        checks++; if ({obs_wbv, obs_wbmul, obs_ready, obs_stall, obs_fire} !== 5'b00100) begin
            errors++; $display("FAIL reset_init_flags: got %b expected 00100", {obs_wbv, obs_wbmul, obs_ready, obs_stall, obs_fire});
        end
        checks++; if (obs_cnt !== 0 || obs_wbrd !== 0) begin
            errors++; $display("FAIL reset_init_cnt_rd: got cnt=%0d rd=%0d expected 0 0", obs_cnt, obs_wbrd);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 10 + k, 0); tick();
        end
        idle(); tick();
        checks++; if (obs_cnt !== 3) begin
            errors++; $display("FAIL reset_pre_cnt: got %0d expected 3", obs_cnt);
        end
        reset = 1'b1;
        tick();
        drive(1, 0, 1, 1, 10, 0, 0, 1, 0);
        tick();
        checks++; if ({obs_wbv, obs_ready, obs_stall, obs_fire} !== 4'b0100) begin
            errors++; $display("FAIL reset_mid_flags: got %b expected 0100", {obs_wbv, obs_ready, obs_stall, obs_fire});
        end
        checks++; if (obs_cnt !== 0) begin
            errors++; $display("FAIL reset_mid_cnt: got %0d expected 0", obs_cnt);
        end
        idle();
        reset = 1'b0;
        stale = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (obs_wbv || obs_cnt != 0) stale = 1;
        end
        checks++; if (stale !== 1'b0) begin
            errors++; $display("FAIL reset_no_stale_wb: got %0b expected 0", stale);
        end
    endtask

    task automatic test_raw();
        bit fired = 0, st_all;
        int ft = -1;
        drain();
        for (int k = 0; k < 12; k++) begin
            if (k == 0) drive(1, 1, 1, 0, 0, 0, 0, 5, 0);
            else if (!fired) drive(1, 0, 1, 1, 5, 1, 1, 6, 0);
            else idle();
            tick(); rec(k);
            if (k > 0 && obs_fire && !fired) begin fired = 1; ft = k; end
        end
        st_all = log_stall[1] & log_stall[2] & log_stall[3] & log_stall[4];
        checks++; if (st_all !== 1'b1) begin
            errors++; $display("FAIL raw_stall_t1_t4: got %0b expected 1", st_all);
        end
        checks++; if (ft !== (FWD ? 5 : 6)) begin
            errors++; $display("FAIL raw_fire_cycle: got %0d expected %0d", ft, FWD ? 5 : 6);
        end
        checks++; if ({log_wbv[5], log_rd[5], log_sel[5]} !== {1'b1, 5, 1'b1}) begin
            errors++; $display("FAIL raw_mul_wb_t5: got v=%0b rd=%0d mul=%0b expected 1 5 1", log_wbv[5], log_rd[5], log_sel[5]);
        end
        checks++; if ((ft > 0 ? log_wbv[ft] : 1'bx) !== FWD) begin
            errors++; $display("FAIL raw_wb_at_fire: got %0b expected %0b", ft > 0 ? log_wbv[ft] : 1'bx, FWD);
        end
    endtask

    task automatic test_struct();
        bit fired = 0;
        drain();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) drive(1, 1, 1, 0, 0, 0, 0, 7, 0);
            else if (k >= 4 && !fired) drive(1, 0, 1, 1, 1, 0, 0, 8, 0);
            else idle();
            tick(); rec(k);
            if (k >= 4 && obs_fire) fired = 1;
        end
        checks++; if ({log_stall[4], log_fire[4], log_fire[5]} !== 3'b101) begin
            errors++; $display("FAIL struct_stall_fire: got %b expected 101", {log_stall[4], log_fire[4], log_fire[5]});
        end
        checks++; if ({log_wbv[5], log_rd[5], log_sel[5]} !== {1'b1, 7, 1'b1}) begin
            errors++; $display("FAIL struct_wb_t5: got v=%0b rd=%0d mul=%0b expected 1 7 1", log_wbv[5], log_rd[5], log_sel[5]);
        end
        checks++; if ({log_wbv[6], log_rd[6], log_sel[6]} !== {1'b1, 8, 1'b0}) begin
            errors++; $display("FAIL struct_wb_t6: got v=%0b rd=%0d mul=%0b expected 1 8 0", log_wbv[6], log_rd[6], log_sel[6]);
        end
    endtask

    task automatic test_waw();
        bit fired = 0;
        int ft = -1;
        drain();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) drive(1, 1, 1, 0, 0, 0, 0, 9, 0);
            else if (!fired) drive(1, 0, 1, 0, 0, 0, 0, 9, 0);
            else idle();
            tick(); rec(k);
            if (k > 0 && obs_fire && !fired) begin fired = 1; ft = k; end
        end
        checks++; if (ft !== 5) begin
            errors++; $display("FAIL waw_fire_cycle: got %0d expected 5", ft);
        end
        checks++; if ({log_wbv[5], log_rd[5], log_sel[5], log_wbv[6], log_rd[6], log_sel[6]} !==
                      {1'b1, 9, 1'b1, 1'b1, 9, 1'b0}) begin
            errors++; $display("FAIL waw_wb_order: got t5=%0b/%0d/%0b t6=%0b/%0d/%0b expected 1/9/1 1/9/0",
                               log_wbv[5], log_rd[5], log_sel[5], log_wbv[6], log_rd[6], log_sel[6]);
        end
    endtask

    task automatic test_flush();
        drain();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1, 0, 1, 0, 0, 0, 0, 3, 1);
            else if (k == 1) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
            else idle();
            tick(); rec(k);
        end
        checks++; if ({log_fire[0], log_stall[0], log_fire[1]} !== 3'b001) begin
            errors++; $display("FAIL flush_fire: got %b expected 001", {log_fire[0], log_stall[0], log_fire[1]});
        end
        checks++; if (log_cnt[1] !== 0 || log_cnt[2] !== 0 || log_cnt[3] !== 0) begin
            errors++; $display("FAIL flush_cnt: got %0d %0d %0d expected 0 0 0", log_cnt[1], log_cnt[2], log_cnt[3]);
        end
        checks++; if ({log_wbv[1], log_wbv[2], log_wbv[3]} !== 3'b000) begin
            errors++; $display("FAIL flush_no_wb: got %b expected 000", {log_wbv[1], log_wbv[2], log_wbv[3]});
        end
    endtask

    task automatic test_back_to_back();
        bit all_fire;
        drain();
        for (int k = 0; k < 12; k++) begin
            if (k < 5) drive(1, 1, 1, 0, 0, 0, 0, 10 + k, 0);
            else idle();
            tick(); rec(k);
        end
        all_fire = log_fire[0] & log_fire[1] & log_fire[2] & log_fire[3] & log_fire[4];
        checks++; if (all_fire !== 1'b1) begin
            errors++; $display("FAIL b2b_fire: got %0b expected 1", all_fire);
        end
        checks++; if (log_cnt[5] !== 5) begin
            errors++; $display("FAIL b2b_cnt_sat: got %0d expected 5", log_cnt[5]);
        end
        for (int j = 0; j < 5; j++) begin
            checks++; if ({log_wbv[5+j], log_rd[5+j], log_sel[5+j]} !== {1'b1, 10 + j, 1'b1}) begin
                errors++; $display("FAIL b2b_wb_%0d: got v=%0b rd=%0d mul=%0b expected 1 %0d 1",
                                   j, log_wbv[5+j], log_rd[5+j], log_sel[5+j], 10 + j);
            end
        end
        checks++; if (log_wbv[10] !== 1'b0) begin
            errors++; $display("FAIL b2b_wb_end: got %0b expected 0", log_wbv[10]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7) == 0);
            tick();
            checks++; if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready c=%0d: got %0b expected %0b", c, obs_ready, exp_ready);
            end
            checks++; if (obs_stall !== exp_stall) begin
                errors++; $display("FAIL rand_stall c=%0d: got %0b expected %0b", c, obs_stall, exp_stall);
            end
            checks++; if (obs_fire !== exp_fire) begin
                errors++; $display("FAIL rand_fire c=%0d: got %0b expected %0b", c, obs_fire, exp_fire);
            end
            checks++; if (obs_wbv !== exp_wbv) begin
                errors++; $display("FAIL rand_wbv c=%0d: got %0b expected %0b", c, obs_wbv, exp_wbv);
            end
            if (exp_wbv) begin
                checks++; if (obs_wbrd !== exp_wbrd || obs_wbmul !== exp_wbmul) begin
                    errors++; $display("FAIL rand_wb c=%0d: got rd=%0d mul=%0b expected rd=%0d mul=%0b",
                                       c, obs_wbrd, obs_wbmul, exp_wbrd, exp_wbmul);
                end
            end
            checks++; if (obs_cnt !== exp_cnt) begin
                errors++; $display("FAIL rand_cnt c=%0d: got %0d expected %0d", c, obs_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_struct();
        test_waw();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
